// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - LSU initiator for the word-addressed DPI memory port
// Optional load/store performance counters are enabled by defining LSU_PERF_CNT_EN.
module lsu_mem_initiator #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_valid,
   output logic        mem_wen,
   output logic [31:0] mem_raddr,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   output logic [31:0] perf_ld_cnt,
   output logic [31:0] perf_st_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

   state_t      r_state;
   state_t      w_next;
   logic        r_wen;
   logic        r_unsigned;
   logic        r_err;
   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [3:0]  r_lat_cnt;

   logic        w_bad;
   logic [4:0]  w_shamt;
   logic [31:0] w_ld_shift;
   logic [31:0] w_ld_data;
   logic [3:0]  w_mask4;

   assign w_bad = (req_size == 2'd3)
                | ((req_size == 2'd1) & req_addr[0])
                | ((req_size == 2'd2) & (req_addr[1:0] != 2'd0));

   assign w_shamt    = {r_addr[1:0], 3'b000};
   assign w_ld_shift = mem_rdata >> w_shamt;

   always_comb begin
      w_ld_data = w_ld_shift;
      w_mask4   = 4'hF;
      case (r_size)
         2'd0: begin
            w_ld_data = {{24{~r_unsigned & w_ld_shift[7]}}, w_ld_shift[7:0]};
            w_mask4   = 4'b0001 << r_addr[1:0];
         end
         2'd1: begin
            w_ld_data = {{16{~r_unsigned & w_ld_shift[15]}}, w_ld_shift[15:0]};
            w_mask4   = 4'b0011 << r_addr[1:0];
         end
         default: begin
            w_ld_data = w_ld_shift;
            w_mask4   = 4'hF;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // All memory/response outputs decode from state so reset clears them at once.
   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      mem_valid  = 1'b0;
      mem_wen    = 1'b0;
      mem_raddr  = 32'd0;
      mem_waddr  = 32'd0;
      mem_wdata  = 32'd0;
      mem_wmask  = 8'd0;
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      resp_err   = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = w_bad ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            mem_valid = 1'b1;
            mem_raddr = {r_addr[31:2], 2'b00};
            mem_waddr = {r_addr[31:2], 2'b00};
            if (r_wen) begin
               mem_wen   = 1'b1;
               mem_wdata = r_wdata << w_shamt;
               mem_wmask = {4'b0000, w_mask4};
               w_next    = S_RESP;
            end else if (r_lat_cnt == LAT_LAST) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = r_rdata;
            resp_err   = r_err;
            if (resp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wen      <= 1'b0;
         r_unsigned <= 1'b0;
         r_err      <= 1'b0;
         r_size     <= 2'd0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_rdata    <= 32'd0;
         r_lat_cnt  <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_wen      <= req_wen;
                  r_unsigned <= req_unsigned;
                  r_err      <= w_bad;
                  r_size     <= req_size;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_rdata    <= 32'd0;
                  r_lat_cnt  <= 4'd0;
               end
            end
            S_ACCESS: begin
               if (!r_wen) begin
                  if (r_lat_cnt == LAT_LAST) r_rdata <= w_ld_data;
                  else                       r_lat_cnt <= r_lat_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LSU_PERF_CNT_EN
   logic        w_done;
   logic [31:0] r_ld_cnt;
   logic [31:0] r_st_cnt;

   assign w_done = (r_state == S_RESP) & resp_ready & ~r_err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ld_cnt <= 32'd0;
         r_st_cnt <= 32'd0;
      end else if (w_done) begin
         if (r_wen) r_st_cnt <= r_st_cnt + 32'd1;
         else       r_ld_cnt <= r_ld_cnt + 32'd1;
      end
   end

   assign perf_ld_cnt = r_ld_cnt;
   assign perf_st_cnt = r_st_cnt;
`else
   assign perf_ld_cnt = 32'd0;
   assign perf_st_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - directed bench for lsu_mem_initiator
module tb_lsu_mem_initiator;
   localparam int MEM_LAT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_valid;
   logic        mem_wen;
   logic [31:0] mem_raddr;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic [31:0] perf_ld_cnt;
   logic [31:0] perf_st_cnt;

   int total = 0;
   int bad   = 0;
   int mv_cnt = 0;
   int wr_cnt = 0;
   int lat;
   int mv0, wr0;
   logic [31:0] cap_raddr, cap_waddr, cap_wdata, hold_rdata;
   logic [7:0]  cap_wmask;
   logic        cap_wen;
   logic        seen;

   always #5 clk = ~clk;

   lsu_mem_initiator #(.MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
      .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata),
      .perf_ld_cnt(perf_ld_cnt), .perf_st_cnt(perf_st_cnt)
   );

   always @(negedge clk) begin
      if (mem_valid) mv_cnt++;
      if (mem_valid && mem_wen) wr_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns);
      @(negedge clk);
      mv0 = mv_cnt;
      wr0 = wr_cnt;
      req_valid = 1'b1; req_wen = wen; req_addr = addr;
      req_wdata = wdata; req_size = size; req_unsigned = uns;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      cap_raddr = 32'd0; cap_waddr = 32'd0; cap_wdata = 32'd0;
      cap_wmask = 8'd0; cap_wen = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (mem_valid) begin
            cap_raddr = mem_raddr; cap_waddr = mem_waddr; cap_wdata = mem_wdata;
            cap_wmask = mem_wmask; cap_wen = mem_wen;
         end
         if (resp_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic handshake;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0;
      req_wdata = 32'd0; req_size = 2'd0; req_unsigned = 1'b0;
      resp_ready = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      chk("rst_perf_ld", perf_ld_cnt, 0);
      rst_n = 1'b1;

      // word load
      mem_rdata = 32'hDEADBEEF;
      issue(1'b0, 32'h8000_0004, 32'd0, 2'd2, 1'b0);
      chk("wl_latency", lat, MEM_LAT + 1);
      chk("wl_raddr", cap_raddr, 32'h8000_0004);
      chk("wl_wen", cap_wen, 0);
      chk("wl_mv_cycles", mv_cnt - mv0, MEM_LAT);
      chk("wl_rdata", resp_rdata, 32'hDEADBEEF);
      chk("wl_err", resp_err, 0);
      handshake();

      // signed and unsigned byte load
      mem_rdata = 32'h80FF1234;
      issue(1'b0, 32'h8000_0003, 32'd0, 2'd0, 1'b0);
      chk("sb_raddr", cap_raddr, 32'h8000_0000);
      chk("sb_rdata", resp_rdata, 32'hFFFF_FF80);
      handshake();
      issue(1'b0, 32'h8000_0003, 32'd0, 2'd0, 1'b1);
      chk("ub_rdata", resp_rdata, 32'h0000_0080);
      handshake();

      // half store
      issue(1'b1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 1'b0);
      chk("hs_latency", lat, 2);
      chk("hs_waddr", cap_waddr, 32'h8000_0000);
      chk("hs_wdata", cap_wdata, 32'hABCD_0000);
      chk("hs_wmask", cap_wmask, 8'h0C);
      chk("hs_writes", wr_cnt - wr0, 1);
      chk("hs_rdata", resp_rdata, 0);
      handshake();

      // misaligned word load
      issue(1'b0, 32'h8000_0001, 32'd0, 2'd2, 1'b0);
      chk("mis_latency", lat, 1);
      chk("mis_err", resp_err, 1);
      chk("mis_rdata", resp_rdata, 0);
      chk("mis_mv_cycles", mv_cnt - mv0, 0);
      handshake();

      // backpressure: response held, new request ignored
      mem_rdata = 32'h8001_0000;
      issue(1'b0, 32'h8000_0006, 32'd0, 2'd1, 1'b0);
      hold_rdata = resp_rdata;
      chk("bp_rdata", hold_rdata, 32'hFFFF_8001);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010; req_size = 2'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_resp_valid", resp_valid, 1);
         chk("bp_rdata_stable", resp_rdata, hold_rdata);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_mem_valid", mem_valid, 0);
      end
      req_valid = 1'b0;
      handshake();
      @(negedge clk);
      chk("bp_after_resp_valid", resp_valid, 0);
      chk("bp_after_req_ready", req_ready, 1);

      // top-of-memory byte load
      mem_rdata = 32'h1122_3344;
      issue(1'b0, 32'hFFFF_FFFF, 32'd0, 2'd0, 1'b0);
      chk("top_raddr", cap_raddr, 32'hFFFF_FFFC);
      chk("top_err", resp_err, 0);
      chk("top_rdata", resp_rdata, 32'h0000_0011);
      handshake();

      // word store
      issue(1'b1, 32'h8000_0008, 32'h1234_5678, 2'd2, 1'b0);
      chk("ws_wdata", cap_wdata, 32'h1234_5678);
      chk("ws_wmask", cap_wmask, 8'h0F);
      chk("ws_writes", wr_cnt - wr0, 1);
      handshake();

      // illegal size
      issue(1'b0, 32'h8000_0000, 32'd0, 2'd3, 1'b0);
      chk("sz3_latency", lat, 1);
      chk("sz3_err", resp_err, 1);
      chk("sz3_mv_cycles", mv_cnt - mv0, 0);
      handshake();

      @(negedge clk);
`ifdef LSU_PERF_CNT_EN
      chk("perf_ld", perf_ld_cnt, 5);
      chk("perf_st", perf_st_cnt, 2);
`else
      chk("perf_ld", perf_ld_cnt, 0);
      chk("perf_st", perf_st_cnt, 0);
`endif

      // reset during ACCESS abandons the load
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0004; req_size = 2'd2;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("ra_mem_valid_before", mem_valid, 1);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("ra_mem_valid", mem_valid, 0);
      chk("ra_req_ready", req_ready, 1);
      chk("ra_resp_valid", resp_valid, 0);
      chk("ra_perf_ld", perf_ld_cnt, 0);
      rst_n = 1'b1;
      resp_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < MEM_LAT + 3; i++) begin
         @(negedge clk);
         if (resp_valid || mem_valid) seen = 1'b1;
      end
      resp_ready = 1'b0;
      chk("ra_no_response", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Initiator side of the DPI memory port. Accepts one load/store request at a time from the core's EXU.
- Drives the word-addressed memory interface: valid, wen, raddr, waddr, wdata, 8-bit wmask, with rdata returned.
- Performs byte-lane steering, mask generation, load extraction and sign/zero extension.
- Returns one response per request through a valid/ready handshake.

Parameters:
- MEM_LAT, 1, cycles mem_valid is held for a load before mem_rdata is sampled (range 1..15).

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  core request valid
- req_ready  output  1  block can accept a request
- req_wen  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_unsigned  input  1  load zero-extends when 1
- resp_valid  output  1  response valid
- resp_ready  input  1  core accepts response
- resp_rdata  output  32  extended load data; 0 for stores
- resp_err  output  1  misaligned or illegal-size request
- mem_valid  output  1  memory access valid
- mem_wen  output  1  memory write enable
- mem_raddr  output  32  word-aligned read address
- mem_waddr  output  32  word-aligned write address
- mem_wdata  output  32  lane-shifted store data
- mem_wmask  output  8  byte mask; bits [7:4] always 0
- mem_rdata  input  32  memory read data
- perf_ld_cnt  output  32  load counter (see Optional Feature)
- perf_st_cnt  output  32  store counter (see Optional Feature)

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - State goes to IDLE.
  - All mem_* outputs, resp_valid, resp_err, resp_rdata and counters go to 0.
  - req_ready goes to 1.
  - An in-flight access is abandoned with no response.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the request.
  - If misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or req_size = 3: go to RESP with resp_err = 1 and issue no memory access.
  - Otherwise go to ACCESS.
- ACCESS:
  - req_ready = 0 and mem_valid = 1.
  - mem_raddr and mem_waddr both equal addr & 0xFFFFFFFC.
  - Load: mem_wen = 0; held for MEM_LAT cycles. mem_rdata is sampled on the last ACCESS cycle, then go to RESP.
  - Store: mem_wen = 1 for exactly one cycle, then go to RESP. The memory must see exactly one write per store.
- Store lane rules, with o = addr[1:0]:
  - mem_wdata = req_wdata << (8*o).
  - Byte: mem_wmask = 1 << o. Half: 3 << o. Word: 0xF.
  - When not storing, mem_wmask = 0 and mem_wdata = 0.
- Load extraction:
  - d = rdata_latched >> (8*o).
  - Byte: d[7:0] extended; half: d[15:0] extended; word: d.
  - Extension is sign unless req_unsigned = 1.
- RESP:
  - resp_valid = 1, with resp_rdata and resp_err stable.
  - mem_valid = 0.
  - Held until resp_ready = 1, then go to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake (no back-to-back overlap).
- Latency, with request accepted at edge 0:
  - Load: resp_valid first high in cycle MEM_LAT + 1.
  - Store: resp_valid first high in cycle 2.
  - Error: resp_valid first high in cycle 1.
- Boundary cases:
  - req_valid is ignored outside IDLE.
  - resp_ready low stalls indefinitely with outputs held.
  - Address 0xFFFFFFFF byte load is legal; aligned address is 0xFFFFFFFC.
  - Error responses return resp_rdata = 0.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined:
  - perf_ld_cnt increments on each completed load handshake (resp_valid & resp_ready, not an error).
  - perf_st_cnt does the same for stores.
  - Counters wrap at 2^32 and are cleared by reset.
- Undefined: both outputs are tied to constant 0 and no counter flops are present.

Test Plan:
- Word load: addr 0x80000004, memory word 0xDEADBEEF, MEM_LAT = 1 -> mem_raddr 0x80000004; resp_rdata 0xDEADBEEF, resp_err 0, resp_valid in cycle 2.
- Signed byte load: addr 0x80000003, word 0x80FF1234 -> resp_rdata 0xFFFFFF80. Same load with req_unsigned = 1 -> 0x00000080.
- Half store: addr 0x80000002, wdata 0x0000ABCD -> one cycle with mem_wen = 1, mem_waddr 0x80000000, mem_wdata 0xABCD0000, mem_wmask 0x0C. Exactly one write observed.
- Misaligned word load at 0x80000001 -> no mem_valid pulse; resp_valid in cycle 1 with resp_err = 1, resp_rdata 0.
- Backpressure and reset: hold resp_ready = 0 for 5 cycles -> response held stable. Assert rst_n = 0 during ACCESS with MEM_LAT = 4 -> next cycle mem_valid = 0, req_ready = 1, no response.
- With LSU_PERF_CNT_EN: 3 loads, 2 stores, 1 misaligned -> perf_ld_cnt = 3, perf_st_cnt = 2. Without the macro -> both read 0.
